// File: rtl/seg7_pkg.sv
// Shared types for the 7-segment scanner: FSM state encoding and hex-to-segment table.
package seg7_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DWELL
  } state_e;

  // Active-high segments, bit0=a .. bit6=g; entry 0 is the rightmost.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decode.sv
// Nibble + decimal point (+ blank) to an SR_W-wide segment pattern, dp in bit 7.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int SR_W = 8
) (
  input  logic [3:0]      nib_i,
  input  logic            dp_i,
  input  logic            blank_i,
  output logic [SR_W-1:0] pat_o
);

  localparam int NB = (SR_W < 8) ? SR_W : 8;

  logic [7:0] seg8;

  always_comb begin
    seg8          = {dp_i, blank_i ? 7'h00 : SEG_TAB[nib_i]};
    pat_o         = '0;
    pat_o[NB-1:0] = seg8[NB-1:0];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-seg scanner driving two 595-style chains on a shared shift clock.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SR_W      = 8,
  parameter int HALF_DIV  = 4,
  parameter int DWELL_CYC = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [4*DIGITS-1:0] disp_data,
  input  logic [DIGITS-1:0]   disp_dp,
  input  logic                disp_wr,
  output logic                seg_ser,
  output logic                com_ser,
  output logic                srclk,
  output logic                seg_rclk,
  output logic                com_rclk,
  output logic                busy,
  output logic                frame_done
);

  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW   = (SR_W > 1) ? $clog2(SR_W) : 1;
  localparam int CMAX = (HALF_DIV > DWELL_CYC) ? HALF_DIV : DWELL_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] HD_LAST  = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] DWL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SR_W - 1);

  state_e              state_q, state_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SR_W-1:0]     seg_pat_q, seg_pat_d;
  logic [SR_W-1:0]     com_pat_q, com_pat_d;
  logic [4*DIGITS-1:0] shd_data_q, shd_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic                fdone_q, fdone_d;

  logic [3:0]      nib;
  logic            blank;
  logic [SR_W-1:0] dec_pat;
  logic            ph_end, dwell_end;

  assign nib = act_data_q[{dig_q, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  // Blank when this nibble and every nibble above it are zero.
  assign blank = (dig_q != '0) && ((act_data_q >> {dig_q, 2'b00}) == '0);
`else
  assign blank = 1'b0;
`endif

  seg7_decode #(.SR_W(SR_W)) u_dec (
    .nib_i  (nib),
    .dp_i   (act_dp_q[dig_q]),
    .blank_i(blank),
    .pat_o  (dec_pat)
  );

  assign ph_end    = (cnt_q == HD_LAST);
  assign dwell_end = (cnt_q == DWL_LAST);

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    seg_pat_d  = seg_pat_q;
    com_pat_d  = com_pat_q;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    fdone_d    = 1'b0;

    if (disp_wr) begin
      shd_data_d = disp_data;
      shd_dp_d   = disp_dp;
    end

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = LOAD;
          act_data_d = shd_data_q;
          act_dp_d   = shd_dp_q;
          dig_d      = '0;
        end
      end
      LOAD: begin
        seg_pat_d = dec_pat;
        com_pat_d = SR_W'(1) << dig_q;
        bit_d     = BIT_LAST;
        cnt_d     = '0;
        state_d   = SHIFT_LO;
      end
      SHIFT_LO: begin
        cnt_d = cnt_q + 1'b1;
        if (ph_end) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        cnt_d = cnt_q + 1'b1;
        if (ph_end) begin
          cnt_d = '0;
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        cnt_d = cnt_q + 1'b1;
        if (ph_end) begin
          cnt_d   = '0;
          state_d = DWELL;
        end
      end
      DWELL: begin
        cnt_d = cnt_q + 1'b1;
        if (dwell_end) begin
          cnt_d   = '0;
          state_d = en ? LOAD : IDLE;
          if (dig_q == DIG_LAST) begin
            // Frame boundary: shadow sampled before any same-cycle write lands.
            dig_d      = '0;
            fdone_d    = 1'b1;
            act_data_d = shd_data_q;
            act_dp_d   = shd_dp_q;
          end else begin
            dig_d = dig_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dig_q      <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      seg_pat_q  <= '0;
      com_pat_q  <= '0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      seg_pat_q  <= seg_pat_d;
      com_pat_q  <= com_pat_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      fdone_q    <= fdone_d;
    end
  end

  logic shifting;
  assign shifting   = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);
  assign seg_ser    = shifting & seg_pat_q[bit_q];
  assign com_ser    = shifting & com_pat_q[bit_q];
  assign srclk      = (state_q == SHIFT_HI);
  assign seg_rclk   = (state_q == LATCH);
  assign com_rclk   = (state_q == LATCH);
  assign busy       = (state_q != IDLE);
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a 595 model in the monitor checks each latched digit.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] disp_data = '0;
  logic [3:0]  disp_dp = '0;
  logic        disp_wr = 1'b0;
  logic        seg_ser, com_ser, srclk, seg_rclk, com_rclk, busy, frame_done;

  seg7_scan_ctrl #(.DIGITS(4), .SR_W(8), .HALF_DIV(4), .DWELL_CYC(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .disp_data (disp_data),
    .disp_dp   (disp_dp),
    .disp_wr   (disp_wr),
    .seg_ser   (seg_ser),
    .com_ser   (com_ser),
    .srclk     (srclk),
    .seg_rclk  (seg_rclk),
    .com_rclk  (com_rclk),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'h3F; 4'h1: hex7 = 8'h06; 4'h2: hex7 = 8'h5B; 4'h3: hex7 = 8'h4F;
      4'h4: hex7 = 8'h66; 4'h5: hex7 = 8'h6D; 4'h6: hex7 = 8'h7D; 4'h7: hex7 = 8'h07;
      4'h8: hex7 = 8'h7F; 4'h9: hex7 = 8'h6F; 4'hA: hex7 = 8'h77; 4'hB: hex7 = 8'h7C;
      4'hC: hex7 = 8'h39; 4'hD: hex7 = 8'h5E; 4'hE: hex7 = 8'h79; default: hex7 = 8'h71;
    endcase
  endfunction

  // Expected {seg, com} bytes for digit d of a frame.
  function automatic logic [15:0] exp_ent(input logic [15:0] data, input logic [3:0] dp, input int d);
    logic [15:0] sh;
    logic [7:0]  s, c;
    sh = data >> (4 * d);
    s  = hex7(sh[3:0]);
`ifdef SEG7_LZ_BLANK_EN
    if (d != 0 && sh == 16'h0) s = 8'h00;
`endif
    s[7] = dp[d];
    c = 8'h01 << d;
    return {s, c};
  endfunction

  task automatic push_frame(input logic [15:0] data, input logic [3:0] dp, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_ent(data, dp, i));
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2000);
    check("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic write_disp(input logic [15:0] data, input logic [3:0] dp);
    disp_data = data;
    disp_dp   = dp;
    disp_wr   = 1'b1;
    @(negedge clk);
    disp_wr   = 1'b0;
  endtask

  // Monitor: models both 595 chains and compares each latched digit with the queue.
  logic [7:0] sr_seg = '0, sr_com = '0;
  int   edges = 0, edges_total = 0, rw = 0;
  logic srclk_p = 1'b0, rclk_p = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      edges   = 0;
      rw      = 0;
      srclk_p = 1'b0;
      rclk_p  = 1'b0;
    end else begin
      if (srclk && !srclk_p) begin
        sr_seg = {sr_seg[6:0], seg_ser};
        sr_com = {sr_com[6:0], com_ser};
        edges++;
        edges_total++;
      end
      if (seg_rclk && !rclk_p) begin
        check("rclk_pair", 32'(com_rclk), 32'd1);
        check("bits_per_digit", 32'(edges), 32'd8);
        check("latch_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("digit_pattern", 32'({sr_seg, sr_com}), 32'(exp_q.pop_front()));
        edges = 0;
        rw    = 0;
      end
      if (seg_rclk) rw++;
      if (!seg_rclk && rclk_p) check("rclk_width", 32'(rw), 32'd4);
      srclk_p = srclk;
      rclk_p  = seg_rclk;
    end
  end

  initial begin
    int cnt;
    int tot;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({seg_ser, com_ser, srclk, seg_rclk, com_rclk, busy, frame_done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: 1234, with en-to-first-srclk latency.
    write_disp(16'h1234, 4'b0000);
    push_frame(16'h1234, 4'b0000, 4);
    en  = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!srclk && cnt < 50);
    check("first_srclk_latency", 32'(cnt), 32'd6);
    write_disp(16'h0000, 4'b0100);

    // Frame 2: zeros with dp on digit 2; also measure frame period.
    wait_fd();
    push_frame(16'h0000, 4'b0100, 4);
    disp_data = 16'hAAAA;
    disp_dp   = 4'b0000;
    disp_wr   = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      disp_wr = 1'b0;
      cnt++;
    end while (!frame_done && cnt < 2000);
    check("frame_period", 32'(cnt), 32'd676);

    // Frame 3 shows AAAA; write 5555 on the exact cycle of the next frame copy.
    push_frame(16'hAAAA, 4'b0000, 4);
    repeat (675) @(negedge clk);
    disp_data = 16'h5555;
    disp_wr   = 1'b1;
    @(negedge clk);
    disp_wr = 1'b0;
    check("copy_cycle_frame_done", 32'(frame_done), 32'd1);
    push_frame(16'hAAAA, 4'b0000, 4);

    // Frame 5 shows 5555; drop en during digit 1 SHIFT_HI.
    wait_fd();
    push_frame(16'h5555, 4'b0000, 2);
    repeat (176) @(negedge clk);
    check("srclk_high_digit1", 32'(srclk), 32'd1);
    en  = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy && cnt < 1000);
    check("busy_fall_delay", 32'(cnt), 32'd162);
    tot = edges_total;
    repeat (400) @(negedge clk);
    check("no_srclk_after_idle", 32'(edges_total), 32'(tot));

    // Leading-zero data, written while disabled.
    write_disp(16'h0045, 4'b0000);
    push_frame(16'h0045, 4'b0000, 4);
    en = 1'b1;
    wait_fd();
    push_frame(16'h0045, 4'b0000, 1);
    repeat (66) @(negedge clk);
    check("in_latch_before_rst", 32'(seg_rclk), 32'd1);
    #1 rst = 1'b1;
    #1 check("outputs_on_rst", 32'({seg_ser, com_ser, srclk, seg_rclk, com_rclk, busy, frame_done}), 32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_after_rst", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
